// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the instruction-fetch sequencer: branch decisions,
// FSM states and reset defaults.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        BC_JALR  = 2'd0,
        BC_TAKEN = 2'd1,
        BC_SEQ   = 2'd2
    } b_ctrl_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/fetch_seq_redirect_unit.sv
// Combinational redirect decode: target select, JALR bit0 mask and
// word-alignment check of the resolved branch.
module redirect_unit
    import fetch_seq_pkg::*;
(
    input  logic        br_valid,
    input  logic [1:0]  b_ctrl,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    output logic        redir,
    output logic        misalign,
    output logic [31:0] target
);

    logic is_event;

    always_comb begin
        is_event = br_valid && ((b_ctrl == BC_JALR) || (b_ctrl == BC_TAKEN));
        target   = (b_ctrl == BC_JALR) ? {jalr_target[31:1], 1'b0} : br_target;
        redir    = is_event && (target[1:0] == 2'b00);
        misalign = is_event && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem
// requests, holds fetched instructions under stall and handles redirects.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [1:0]  b_ctrl,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush,
    output logic        misalign_err
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  req_pc, req_pc_nxt;
    logic [31:0]  pend_pc, pend_pc_nxt;
    logic         pend_valid, pend_valid_nxt;
    logic         drop, drop_nxt;
    logic         if_valid_nxt;
    logic [31:0]  if_pc_nxt, if_instr_nxt;
    logic         flush_nxt, misalign_nxt;

    logic         redir, misalign;
    logic [31:0]  target;
    logic         accept;

    redirect_unit u_redirect (
        .br_valid    (br_valid),
        .b_ctrl      (b_ctrl),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .redir       (redir),
        .misalign    (misalign),
        .target      (target)
    );

    assign imem_req_valid = rst_n && (state == ST_FETCH);
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_pc_nxt     = req_pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        drop_nxt       = drop;
        if_valid_nxt   = if_valid && stall;
        if_pc_nxt      = if_pc;
        if_instr_nxt   = if_instr;
        flush_nxt      = redir;
        misalign_nxt   = misalign;

        case (state)
            ST_FETCH: begin
                if (accept) begin
                    req_pc_nxt     = pc;
                    pend_valid_nxt = 1'b0;
                    state_nxt      = ST_WAIT;
                    if (redir) begin
                        pc_nxt   = target;
                        drop_nxt = 1'b1;
                    end else begin
                        pc_nxt   = pend_valid ? pend_pc : pc + 32'(PC_STEP);
                        drop_nxt = pend_valid;
                    end
                end else if (redir) begin
                    // The un-accepted request keeps its address; its response is dropped later.
                    pend_valid_nxt = 1'b1;
                    pend_pc_nxt    = target;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    drop_nxt  = 1'b0;
                    state_nxt = ST_FETCH;
                    if (redir) begin
                        pc_nxt = target;
                    end else if (!drop) begin
                        if_valid_nxt = 1'b1;
                        if_pc_nxt    = req_pc;
                        if_instr_nxt = imem_rsp_data;
                        state_nxt    = stall ? ST_HOLD : ST_FETCH;
                    end
                end else if (redir) begin
                    pc_nxt   = target;
                    drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redir) begin
                    pc_nxt    = target;
                    state_nxt = ST_FETCH;
                end else if (!stall) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase

        if (redir) if_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            req_pc       <= '0;
            pend_valid   <= 1'b0;
            pend_pc      <= '0;
            drop         <= 1'b0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            req_pc       <= req_pc_nxt;
            pend_valid   <= pend_valid_nxt;
            pend_pc      <= pend_pc_nxt;
            drop         <= drop_nxt;
            if_valid     <= if_valid_nxt;
            if_pc        <= if_pc_nxt;
            if_instr     <= if_instr_nxt;
            flush        <= flush_nxt;
            misalign_err <= misalign_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a zero-wait imem model answers accepted
// requests one cycle later; each step checks outputs 1ns after the clock edge.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [1:0]  b_ctrl;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        misalign_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        auto_rsp;

    fetch_seq #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .b_ctrl         (b_ctrl),
        .br_target      (br_target),
        .jalr_target    (jalr_target),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .flush          (flush),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h0000_000C) ? 32'h0050_0093 : (32'hDEAD_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; when auto_rsp is set the imem answers an accepted request next cycle.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = auto_rsp && imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            imem_rsp_valid = acc;
            imem_rsp_data  = acc ? mem_f(a) : 32'h0;
        end
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; b_ctrl = 2'd2; br_target = '0; jalr_target = '0;
        stall = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        auto_rsp = 1'b1;
        tick(); tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_addr", imem_addr, 32'h0);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);

        // zero-wait sequential fetch
        tick();
        chk("seq_wait_req", 32'(imem_req_valid), 32'd0);
        chk("seq_wait_ifv", 32'(if_valid), 32'd0);
        tick();
        chk("seq0_ifv", 32'(if_valid), 32'd1);
        chk("seq0_pc", if_pc, 32'h0);
        chk("seq0_instr", if_instr, 32'hDEAD_0000);
        chk("seq1_addr", imem_addr, 32'h4);

        // ready low for 3 cycles
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nrdy_ifv", 32'(if_valid), 32'd0);
            chk("nrdy_req", 32'(imem_req_valid), 32'd1);
            chk("nrdy_addr", imem_addr, 32'h4);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("nrdy_wait_ifv", 32'(if_valid), 32'd0);
        tick();
        chk("seq4_ifv", 32'(if_valid), 32'd1);
        chk("seq4_pc", if_pc, 32'h4);
        chk("seq8_addr", imem_addr, 32'h8);

        // taken branch while waiting for the 0x8 response
        auto_rsp = 1'b0;
        tick();
        chk("w8_req", 32'(imem_req_valid), 32'd0);
        br_valid = 1'b1; b_ctrl = 2'd1; br_target = 32'h100;
        tick();
        br_valid = 1'b0;
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_ifv", 32'(if_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_f(32'h8);
        tick();
        chk("drop8_ifv", 32'(if_valid), 32'd0);
        chk("drop8_flush", 32'(flush), 32'd0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_req", 32'(imem_req_valid), 32'd1);
        imem_rsp_valid = 1'b0; auto_rsp = 1'b1;
        tick(); tick();
        chk("br_if_valid", 32'(if_valid), 32'd1);
        chk("br_if_pc", if_pc, 32'h100);
        chk("br_if_instr", if_instr, 32'hDEAD_0100);

        // JALR redirects in FETCH while not ready
        imem_req_ready = 1'b0;
        br_valid = 1'b1; b_ctrl = 2'd0; jalr_target = 32'h203;
        tick();
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_flush", 32'(flush), 32'd0);
        chk("mis_addr", imem_addr, 32'h104);
        jalr_target = 32'h201;
        tick();
        br_valid = 1'b0;
        chk("jalr_flush", 32'(flush), 32'd1);
        chk("jalr_mis", 32'(misalign_err), 32'd0);
        chk("jalr_addr_hold", imem_addr, 32'h104);
        imem_req_ready = 1'b1;
        tick();
        chk("jalr_flush_once", 32'(flush), 32'd0);
        tick();
        chk("jalr_drop_ifv", 32'(if_valid), 32'd0);
        chk("jalr_addr", imem_addr, 32'h200);
        tick(); tick();
        chk("jalr_if_pc", if_pc, 32'h200);
        chk("jalr_ifv", 32'(if_valid), 32'd1);

        // taken branch coincident with an accept, then stall hold at 0xC
        br_valid = 1'b1; b_ctrl = 2'd1; br_target = 32'hC;
        tick();
        br_valid = 1'b0;
        chk("acc_br_flush", 32'(flush), 32'd1);
        chk("acc_br_ifv", 32'(if_valid), 32'd0);
        tick();
        chk("acc_br_drop_ifv", 32'(if_valid), 32'd0);
        chk("acc_br_addr", imem_addr, 32'hC);
        stall = 1'b1;
        tick(); tick();
        chk("stall_ifv", 32'(if_valid), 32'd1);
        chk("stall_instr", if_instr, 32'h0050_0093);
        chk("stall_pc", if_pc, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ifv", 32'(if_valid), 32'd1);
            chk("hold_instr", if_instr, 32'h0050_0093);
            chk("hold_req", 32'(imem_req_valid), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstall_ifv", 32'(if_valid), 32'd0);
        chk("unstall_addr", imem_addr, 32'h10);
        chk("unstall_req", 32'(imem_req_valid), 32'd1);

        // redirect coincident with a response in WAIT, then b_ctrl=3 ignored
        tick();
        br_valid = 1'b1; b_ctrl = 2'd1; br_target = 32'h40;
        tick();
        chk("wrsp_flush", 32'(flush), 32'd1);
        chk("wrsp_ifv", 32'(if_valid), 32'd0);
        chk("wrsp_addr", imem_addr, 32'h40);
        b_ctrl = 2'd3; br_target = 32'h80;
        tick();
        br_valid = 1'b0;
        chk("bc3_flush", 32'(flush), 32'd0);
        chk("bc3_mis", 32'(misalign_err), 32'd0);
        tick();
        chk("bc3_if_pc", if_pc, 32'h40);
        chk("bc3_ifv", 32'(if_valid), 32'd1);
        chk("bc3_addr", imem_addr, 32'h44);

        // asynchronous reset while in WAIT
        tick();
        chk("prerst_req", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_instr", if_instr, 32'h0);
        chk("arst_req", 32'(imem_req_valid), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        br_valid = 1'b1; b_ctrl = 2'd1; br_target = 32'h80;
        tick();
        chk("rst_br_flush", 32'(flush), 32'd0);
        br_valid = 1'b0;
        auto_rsp = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        rst_n = 1'b1;
        #1;
        chk("rel_addr", imem_addr, 32'h0);
        chk("rel_req", 32'(imem_req_valid), 32'd1);
        tick();
        chk("stray_rsp_ifv", 32'(if_valid), 32'd0);
        chk("stray_rsp_addr", imem_addr, 32'h0);
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; auto_rsp = 1'b1;
        tick(); tick();
        chk("resume_ifv", 32'(if_valid), 32'd1);
        chk("resume_pc", if_pc, 32'h0);
        chk("resume_instr", if_instr, 32'hDEAD_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer for the RV32I core. It owns the PC and issues single-outstanding requests to instruction memory over a valid/ready handshake. It presents fetched instructions to decode with a stall-hold and consumes the resolved branch decision (b_ctrl) from branch control to redirect, flush and discard wrong-path fetches. It sits between imem and the IF/ID boundary.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous and active-low
br_valid  in  1  execute-stage branch resolution valid this cycle
b_ctrl  in  2  branch decision: 0 = JALR target, 1 = taken/jump to br_target, 2 = sequential, 3 = treated as 2
br_target  in  32  PC-relative target (pc+imm) for b_ctrl=1
jalr_target  in  32  ALU result for b_ctrl=0; bit0 is forced to 0
stall  in  1  decode cannot accept an instruction
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts the request
imem_addr  out  32  fetch address; stable while valid && !ready
imem_rsp_valid  in  1  response data valid (one cycle)
imem_rsp_data  in  32  fetched instruction
if_valid  out  1  instruction valid to decode
if_pc  out  32  PC of if_instr
if_instr  out  32  instruction to decode
flush  out  1  one-cycle pulse: kill younger pipeline stages
misalign_err  out  1  one-cycle pulse: redirect target not word-aligned

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, pend_valid=0, drop=0, if_valid=0, if_pc=0, if_instr=0, flush=0, misalign_err=0. imem_req_valid=0 while rst_n low. Assertion mid-operation aborts everything. A response arriving after release without a request is ignored.
- States: FETCH, WAIT, HOLD. imem_req_valid=1 only in FETCH. imem_addr=pc.
- FETCH: on accept (valid&&ready): req_pc<=pc; pc<=pend_valid ? pend_pc : pc+PC_STEP (32-bit wrap); drop<=pend_valid; pend_valid<=0; go to WAIT.
- WAIT: on imem_rsp_valid: if drop, discard, clear drop, go to FETCH. Otherwise if_valid<=1, if_pc<=req_pc, if_instr<=data; go to FETCH if !stall, else HOLD. Minimum latency is 1 cycle from rsp to if_valid. Peak throughput is one instruction per 2 cycles with a zero-wait imem.
- HOLD: if_valid/if_pc/if_instr held; on !stall go to FETCH.
- if_valid clears the cycle after a cycle with if_valid && !stall, unless a new response loads it.
- Redirect event: br_valid && b_ctrl∈{0,1}. target = b_ctrl==0 ? {jalr_target[31:1],1'b0} : br_target.
  - If target[1:0]!=0: misalign_err pulses next cycle; there is no redirect and no flush.
  - Otherwise flush pulses next cycle, and if_valid<=0 next cycle (overrides any load).
  - FETCH with no accept: pend_valid<=1, pend_pc<=target. The request address stays unchanged, and that request is later dropped.
  - FETCH with accept in the same cycle: pc<=target, drop<=1.
  - WAIT without rsp: pc<=target, drop<=1.
  - WAIT with rsp in the same cycle: response discarded, pc<=target, go to FETCH.
  - HOLD: pc<=target, go to FETCH.
  - Redirect has priority over stall and over normal PC advance.
- b_ctrl 2/3 or br_valid=0: no effect.
- Redirect during reset: ignored.

Decomposition:
- Shared package: b_ctrl encodings (BC_JALR=0, BC_TAKEN=1, BC_SEQ=2), state encoding, RESET_PC default.
- Optional sub-module redirect_unit: combinational target select, JALR bit0 mask, alignment check, redirect-event decode.

Test Plan:
- Reset, then zero-wait imem, stall=0 -> first imem_addr=0x0; if_pc sequence 0x0,0x4,0x8; if_valid pulses every 2nd cycle.
- ready held low 3 cycles -> imem_addr stays 0x4 and imem_req_valid stays high; no if_valid until the response arrives.
- b_ctrl=1, br_target=0x100, while in WAIT for 0x8 -> flush pulses once; the 0x8 response is discarded; next imem_addr=0x100; next if_pc=0x100.
- b_ctrl=0, jalr_target=0x203, redirect in FETCH while not ready -> 0x203 masks to 0x202, so misalign_err pulses with no flush; a jalr_target=0x201 case masks to 0x200, the pending request is dropped, and the next fetch is 0x200.
- stall=1 for 4 cycles after a response of 0x00500093 at pc 0xC -> if_valid/if_instr held and no new imem request; stall release fetches 0x10.
- rst_n pulled low in WAIT -> outputs return to reset values immediately (async); fetch resumes at RESET_PC.
